keypad_scan: RTL and testbench
==============================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000: clk cycles each row is driven before its column sample (minimum 4).
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 8: consecutive identical samples required to accept a press or a release (minimum 2).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: key-code buffer entries (power of two).
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port RST, input, 1 bit: reset, asynchronous assert, active-high.
REQ-006 SHALL have port row, output, 4 bits: matrix row drive, active-low, exactly one bit low at all times.
REQ-007 SHALL have port col, input, 4 bits: matrix column sense, active-low, asynchronous to clk (pulled up when idle).
REQ-008 SHALL have port key_valid, output, 1 bit: key_code holds a buffered code.
REQ-009 SHALL have port key_ready, input, 1 bit: consumer accepts; a pop occurs when key_valid and key_ready are both high.
REQ-010 SHALL have port key_code, output, 4 bits: oldest code, row_idx*4 + col_idx.
REQ-011 SHALL have port key_pressed, output, 1 bit: high while a debounced key is held.
REQ-012 SHALL have port overflow, output, 1 bit: one-cycle pulse when a code is dropped because the FIFO is full.

Function
REQ-013 SHALL pass col through a 2-flop synchronizer; all decisions use the synchronized value only.
REQ-014 SHALL use a slot counter 0..SCAN_DIV-1; a sample is taken when the counter reaches SCAN_DIV-1, and the counter then wraps to 0.
REQ-015 SHALL implement FSM states SCAN, DEBOUNCE, HELD and RELEASE.
REQ-016 SCAN: advance row low-bit 0->1->2->3->0 after each sample; any sampled column low -> latch row_idx and the lowest-index low column, hold the row, go to DEBOUNCE with match count 1.
REQ-017 DEBOUNCE: hold the row; a sample equal to the latched column pattern increments the match count; on reaching DEBOUNCE_CNT -> push the code and go to HELD.
REQ-018 DEBOUNCE: a mismatched sample (including all-high) -> go to SCAN, advance to the next row, push nothing.
REQ-019 HELD: hold the row with key_pressed high; an all-high sample -> go to RELEASE with count 1; any other sample keeps HELD and pushes nothing (no auto-repeat).
REQ-020 RELEASE: all-high samples increment the count; on reaching DEBOUNCE_CNT -> go to SCAN and advance the row; any low sample -> go back to HELD.
REQ-021 When several columns are low, the lowest column index SHALL win; other rows are ignored until return to SCAN.
REQ-022 Push SHALL occur the cycle after the accepting sample; key_valid SHALL rise the cycle after the push (FIFO was empty).
REQ-023 FIFO SHALL be first-in first-out, with registered key_code/key_valid; key_code is stable while key_valid is high and key_ready is low.
REQ-024 Push when full SHALL drop the new code and pulse overflow; a simultaneous push and pop when full SHALL accept the push with no overflow.
REQ-025 key_ready while key_valid is low SHALL have no effect.

Reset
REQ-026 While RST is high: row=4'b1110, key_valid=0, key_code=0, key_pressed=0, overflow=0, FSM=SCAN, counters and FIFO pointers 0, synchronizer flops all-ones.
REQ-027 RST asserted mid-debounce or mid-hold SHALL discard all state and buffered codes; after release, scanning restarts at row 0 with no spurious push.

Structure
REQ-028 Package keypad_pkg SHALL hold the FSM state enum, the 4-bit key-code width constant, and the row reset value 4'b1110.
REQ-029 FIFO SHALL be sub-module key_fifo (parameterized depth and width, pointer-plus-wrap-bit full/empty); scan FSM, synchronizer and counters stay in keypad_scan.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=3, FIFO_DEPTH=4)
REQ-030 Clean press: hold col=4'b1011 while row=4'b1101 -> exactly one code 4'd6, key_pressed high, no further codes until release then re-press.
REQ-031 Bounce: col toggles low/high on alternate samples for 20 samples -> no push, row keeps rotating.
REQ-032 Overflow: key_ready=0, five distinct debounced presses -> codes 1st-4th held in order, overflow pulses once, then draining yields the first four codes.
REQ-033 Simultaneous: FIFO full with key_ready=1 on the push cycle -> no overflow, count stays 4, output order preserved.
REQ-034 Multi-key: cols 1 and 3 low on row 2 -> code 4'd9 only.
REQ-035 Reset mid-HELD: assert RST 1 cycle -> row=4'b1110, key_valid=0; with the key still held after reset, exactly one new push follows a full debounce.

Source files
------------

// File: rtl/keypad_scan_pkg.sv
// Shared types and constants for the keypad scanner: FSM states, key-code width,
// row reset pattern and the column priority helper.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } scan_state_e;

  localparam int          KEY_W     = 4;
  localparam logic [3:0]  ROW_RESET = 4'b1110;

  // Lowest-index active-low column wins when several are pressed together.
  function automatic logic [1:0] first_low(input logic [3:0] c);
    if (!c[0])      first_low = 2'd0;
    else if (!c[1]) first_low = 2'd1;
    else if (!c[2]) first_low = 2'd2;
    else            first_low = 2'd3;
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Valid/ready key-code stream between the keypad scanner (master) and its consumer (slave).
interface keypad_scan_if;
  import keypad_pkg::*;

  logic             key_valid;
  logic             key_ready;
  logic [KEY_W-1:0] key_code;

  modport master (output key_valid, output key_code, input key_ready);
  modport slave  (input key_valid, input key_code, output key_ready);

endinterface

// File: rtl/keypad_scan_fifo.sv
// Key-code FIFO with wrap-bit pointers and registered head/valid outputs; a push
// into a full FIFO is dropped and flagged unless a pop frees the slot that cycle.
module key_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             overflow_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             valid_q, valid_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             full, pop, wr_en;

  always_comb begin
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop      = valid_q && ready_i;
    wr_en    = push_i && (!full || pop);
    ovf_d    = push_i && full && !pop;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_en};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    valid_d  = (wr_ptr_d != rd_ptr_d);
    // The new head is the incoming word when it lands in the slot about to be read.
    if (wr_en && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) data_d = data_i;
    else                                                  data_d = mem_q[rd_ptr_d[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
    end
  end

  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: rotates one active-low row, debounces presses and
// releases on the synchronized columns, and queues key codes in a FIFO.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                clk,
  input  logic                RST,
  output logic [3:0]          row,
  input  logic [3:0]          col,
  output logic                key_pressed,
  output logic                overflow,
  keypad_scan_if.master       key_if
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int CNT_W  = $clog2(DEBOUNCE_CNT + 1);

  logic [3:0]        col_s1_q, col_s2_q;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [1:0]        row_idx_q, row_idx_d;
  logic [1:0]        col_idx_q, col_idx_d;
  logic [3:0]        col_pat_q, col_pat_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  scan_state_e       state_q, state_d;
  logic              push_q, push_d;
  logic              sample;

  always_comb begin
    sample    = (slot_q == SLOT_W'(SCAN_DIV - 1));
    slot_d    = sample ? '0 : slot_q + SLOT_W'(1);
    cnt_inc   = cnt_q + CNT_W'(1);
    state_d   = state_q;
    row_idx_d = row_idx_q;
    col_idx_d = col_idx_q;
    col_pat_d = col_pat_q;
    cnt_d     = cnt_q;
    push_d    = 1'b0;
    if (sample) begin
      case (state_q)
        SCAN: begin
          if (col_s2_q != 4'hF) begin
            state_d   = DEBOUNCE;
            cnt_d     = CNT_W'(1);
            col_pat_d = col_s2_q;
            col_idx_d = first_low(col_s2_q);
          end else begin
            row_idx_d = row_idx_q + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (col_s2_q == col_pat_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(DEBOUNCE_CNT)) begin
              state_d = HELD;
              push_d  = 1'b1;
            end
          end else begin
            state_d   = SCAN;
            row_idx_d = row_idx_q + 2'd1;
          end
        end
        HELD: begin
          if (col_s2_q == 4'hF) begin
            state_d = RELEASE;
            cnt_d   = CNT_W'(1);
          end
        end
        RELEASE: begin
          if (col_s2_q == 4'hF) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(DEBOUNCE_CNT)) begin
              state_d   = SCAN;
              row_idx_d = row_idx_q + 2'd1;
            end
          end else begin
            state_d = HELD;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      col_s1_q  <= 4'hF;
      col_s2_q  <= 4'hF;
      slot_q    <= '0;
      row_idx_q <= 2'd0;
      col_idx_q <= 2'd0;
      col_pat_q <= 4'hF;
      cnt_q     <= '0;
      state_q   <= SCAN;
      push_q    <= 1'b0;
    end else begin
      col_s1_q  <= col;
      col_s2_q  <= col_s1_q;
      slot_q    <= slot_d;
      row_idx_q <= row_idx_d;
      col_idx_q <= col_idx_d;
      col_pat_q <= col_pat_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      push_q    <= push_d;
    end
  end

  assign row         = ~((~ROW_RESET) << row_idx_q);
  assign key_pressed = (state_q == HELD) || (state_q == RELEASE);

  // Row and column indices stay frozen in HELD, so the code is still valid on the push cycle.
  key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KEY_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (RST),
    .push_i     (push_q),
    .data_i     ({row_idx_q, col_idx_q}),
    .ready_i    (key_if.key_ready),
    .valid_o    (key_if.key_valid),
    .data_o     (key_if.key_code),
    .overflow_o (overflow)
  );

endmodule

// File: tb/tb_keypad_scan.sv
// Directed self-checking bench for keypad_scan with a small key-matrix model
// driving the columns from the scanned row.
module tb_keypad_scan;
  import keypad_pkg::*;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 3;
  localparam int FIFO_DEPTH   = 4;
  localparam int BUDGET       = 300;

  logic        clk = 1'b0;
  logic        RST;
  logic [3:0]  row, col;
  logic        key_pressed, overflow;
  logic [15:0] keys;
  logic        useDirect;
  logic [3:0]  directCol;
  int          checks = 0;
  int          errors = 0;
  int          ovfCount = 0;

  keypad_scan_if kif ();

  keypad_scan #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEBOUNCE_CNT),
    .FIFO_DEPTH   (FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .RST         (RST),
    .row         (row),
    .col         (col),
    .key_pressed (key_pressed),
    .overflow    (overflow),
    .key_if      (kif.master)
  );

  always #5 clk = ~clk;

  // Pressed key (r,c) pulls column c low while row r is driven low.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row[r]) col[c] = 1'b0;
    if (useDirect) col = directCol;
  end

  always @(negedge clk) if (overflow) ovfCount++;

  task automatic waitPressed(input logic want, input string name);
    int n = 0;
    while (key_pressed !== want && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (key_pressed !== want) begin
      errors++;
      $display("[TB] FAIL %s: key_pressed=%b expected %b within %0d cycles", name, key_pressed, want, BUDGET);
    end
  endtask

  task automatic waitValid(input string name);
    int n = 0;
    while (kif.key_valid !== 1'b1 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (kif.key_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s: key_valid=%b expected 1 within %0d cycles", name, kif.key_valid, BUDGET);
    end
  endtask

  task automatic popOne(output logic [3:0] code);
    code = kif.key_code;
    kif.key_ready = 1'b1;
    @(negedge clk);
    kif.key_ready = 1'b0;
  endtask

  task automatic pressRelease(input int k);
    keys[k] = 1'b1;
    waitPressed(1'b1, "press_wait");
    keys[k] = 1'b0;
    waitPressed(1'b0, "release_wait");
  endtask

  task automatic test_reset();
    checks++; if (row !== 4'b1110) begin errors++; $display("[TB] FAIL reset_row: got %b expected 1110", row); end
    checks++; if (kif.key_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", kif.key_valid); end
    checks++; if (kif.key_code !== 4'd0) begin errors++; $display("[TB] FAIL reset_code: got %0d expected 0", kif.key_code); end
    checks++; if (key_pressed !== 1'b0) begin errors++; $display("[TB] FAIL reset_pressed: got %b expected 0", key_pressed); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_clean_press();
    logic [3:0] code;
    int extra = 0;
    keys[6] = 1'b1;
    waitValid("clean_valid");
    checks++; if (kif.key_code !== 4'd6) begin errors++; $display("[TB] FAIL clean_code: got %0d expected 6", kif.key_code); end
    checks++; if (key_pressed !== 1'b1) begin errors++; $display("[TB] FAIL clean_pressed: got %b expected 1", key_pressed); end
    checks++; if (row !== 4'b1101) begin errors++; $display("[TB] FAIL clean_row_hold: got %b expected 1101", row); end
    popOne(code);
    checks++; if (kif.key_valid !== 1'b0) begin errors++; $display("[TB] FAIL clean_after_pop: got %b expected 0", kif.key_valid); end
    repeat (60) begin
      @(negedge clk);
      if (kif.key_valid) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("[TB] FAIL clean_no_repeat: got %0d valid cycles expected 0", extra); end
    keys[6] = 1'b0;
    waitPressed(1'b0, "clean_release");
    repeat (10) @(negedge clk);
    keys[6] = 1'b1;
    waitValid("repress_valid");
    checks++; if (kif.key_code !== 4'd6) begin errors++; $display("[TB] FAIL repress_code: got %0d expected 6", kif.key_code); end
    popOne(code);
    keys[6] = 1'b0;
    waitPressed(1'b0, "repress_release");
    repeat (10) @(negedge clk);
  endtask

  task automatic test_bounce();
    int bad = 0;
    logic [3:0] rowSeen = 4'h0;
    useDirect = 1'b1;
    for (int i = 0; i < 20; i++) begin
      directCol = (i % 2 == 0) ? 4'b1110 : 4'b1111;
      repeat (SCAN_DIV) begin
        @(negedge clk);
        if (kif.key_valid || key_pressed) bad++;
        rowSeen |= ~row;
      end
    end
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL bounce_no_push: got %0d bad cycles expected 0", bad); end
    checks++; if (rowSeen !== 4'hF) begin errors++; $display("[TB] FAIL bounce_rotate: rows seen %b expected 1111", rowSeen); end
    directCol = 4'hF;
    useDirect = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_overflow();
    int expCodes [5] = '{1, 4, 11, 14, 3};
    int ovfStart = ovfCount;
    logic [3:0] code;
    kif.key_ready = 1'b0;
    for (int i = 0; i < 5; i++) pressRelease(expCodes[i]);
    repeat (5) @(negedge clk);
    checks++; if (ovfCount - ovfStart !== 1) begin errors++; $display("[TB] FAIL ovf_pulses: got %0d expected 1", ovfCount - ovfStart); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (kif.key_valid !== 1'b1) begin errors++; $display("[TB] FAIL ovf_drain_valid: got %b expected 1", kif.key_valid); end
      popOne(code);
      checks++; if (code !== 4'(expCodes[i])) begin errors++; $display("[TB] FAIL ovf_drain_code: got %0d expected %0d", code, expCodes[i]); end
    end
    checks++; if (kif.key_valid !== 1'b0) begin errors++; $display("[TB] FAIL ovf_empty: got %b expected 0", kif.key_valid); end
  endtask

  task automatic test_simultaneous();
    int fill [4] = '{2, 7, 8, 13};
    int drain [4] = '{7, 8, 13, 15};
    int ovfStart;
    int n = 0;
    logic [3:0] popped = 4'hF;
    logic [3:0] code;
    for (int i = 0; i < 4; i++) pressRelease(fill[i]);
    ovfStart = ovfCount;
    keys[15] = 1'b1;
    while (key_pressed !== 1'b1 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (key_pressed !== 1'b1) begin
      errors++;
      $display("[TB] FAIL simul_press: key_pressed=%b expected 1", key_pressed);
    end else begin
      popOne(popped);
    end
    keys[15] = 1'b0;
    waitPressed(1'b0, "simul_release");
    repeat (5) @(negedge clk);
    checks++; if (popped !== 4'd2) begin errors++; $display("[TB] FAIL simul_pop_code: got %0d expected 2", popped); end
    checks++; if (ovfCount - ovfStart !== 0) begin errors++; $display("[TB] FAIL simul_no_ovf: got %0d pulses expected 0", ovfCount - ovfStart); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (kif.key_valid !== 1'b1) begin errors++; $display("[TB] FAIL simul_drain_valid: got %b expected 1", kif.key_valid); end
      popOne(code);
      checks++; if (code !== 4'(drain[i])) begin errors++; $display("[TB] FAIL simul_drain_code: got %0d expected %0d", code, drain[i]); end
    end
    checks++; if (kif.key_valid !== 1'b0) begin errors++; $display("[TB] FAIL simul_empty: got %b expected 0", kif.key_valid); end
  endtask

  task automatic test_multi_key();
    logic [3:0] code;
    keys[9]  = 1'b1;
    keys[11] = 1'b1;
    waitValid("multi_valid");
    checks++; if (kif.key_code !== 4'd9) begin errors++; $display("[TB] FAIL multi_code: got %0d expected 9", kif.key_code); end
    keys[9]  = 1'b0;
    keys[11] = 1'b0;
    waitPressed(1'b0, "multi_release");
    repeat (10) @(negedge clk);
    popOne(code);
    checks++; if (kif.key_valid !== 1'b0) begin errors++; $display("[TB] FAIL multi_single: got %b expected 0", kif.key_valid); end
  endtask

  task automatic test_reset_mid_held();
    logic [3:0] code;
    int extra = 0;
    keys[6] = 1'b1;
    waitPressed(1'b1, "rst_held_wait");
    repeat (2) @(negedge clk);
    RST = 1'b1;
    #1;
    checks++; if (row !== 4'b1110) begin errors++; $display("[TB] FAIL rst_mid_row: got %b expected 1110", row); end
    checks++; if (kif.key_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_valid: got %b expected 0", kif.key_valid); end
    checks++; if (key_pressed !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_pressed: got %b expected 0", key_pressed); end
    @(negedge clk);
    RST = 1'b0;
    waitValid("rst_repush_valid");
    checks++; if (kif.key_code !== 4'd6) begin errors++; $display("[TB] FAIL rst_repush_code: got %0d expected 6", kif.key_code); end
    popOne(code);
    repeat (40) begin
      @(negedge clk);
      if (kif.key_valid) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("[TB] FAIL rst_single_push: got %0d valid cycles expected 0", extra); end
    keys[6] = 1'b0;
    waitPressed(1'b0, "rst_release");
  endtask

  initial begin
    RST = 1'b1;
    keys = 16'h0;
    useDirect = 1'b0;
    directCol = 4'hF;
    kif.key_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    RST = 1'b0;
    $display("[TB] reset released");
    test_clean_press();
    test_bounce();
    test_overflow();
    test_simultaneous();
    test_multi_key();
    test_reset_mid_held();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
